// File: rtl/lsu_stage.sv
// Load/store stage: single outstanding memory op, byte-lane alignment and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W/D accesses trap instead of issuing a request.
module lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ls_load,
  input  logic        ls_store,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [63:0] alu_res,
  input  logic [63:0] store_data,
  input  logic [4:0]  rd_idx,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        ls_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t      state_reg;
  logic        is_load_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [2:0]  off_reg;

  logic        is_mem;
  logic [2:0]  off;
  logic [7:0]  wmask_next;
  logic [63:0] shifted;
  logic [63:0] load_data;
  logic        trap;

  assign ex_ready = (state_reg == IDLE);
  assign is_mem   = ls_load | ls_store;
  assign off      = alu_res[2:0];
  assign shifted  = mem_rsp_rdata >> {off_reg, 3'b000};

  always_comb begin
    wmask_next = 8'hFF;
    case (ls_size)
      2'b00:   wmask_next = 8'h01 << off;
      2'b01:   wmask_next = 8'h03 << off;
      2'b10:   wmask_next = 8'h0F << off;
      default: wmask_next = 8'hFF;
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (size_reg)
      2'b00:   load_data = unsigned_reg ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_reg ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_data = unsigned_reg ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (ls_size)
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end

  assign trap = is_mem & misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ls_misalign <= 1'b0;
    else     ls_misalign <= ex_valid & ex_ready & trap;
  end
`else
  assign trap        = 1'b0;
  assign ls_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      is_load_reg   <= 1'b0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      off_reg       <= 3'd0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 64'd0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 64'd0;
      mem_req_wdata <= 64'd0;
      mem_req_wmask <= 8'd0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            is_load_reg  <= ls_load;
            size_reg     <= ls_size;
            unsigned_reg <= ls_unsigned;
            off_reg      <= off;
            wb_rd        <= rd_idx;
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b1;
              wb_data  <= alu_res;
            end else if (trap) begin
              wb_valid <= 1'b1;
            end else begin
              state_reg     <= REQ;
              mem_req_valid <= 1'b1;
              // load+store together behaves as a load, so never write
              mem_req_we    <= ls_store & ~ls_load;
              mem_req_addr  <= {alu_res[63:3], 3'b000};
              mem_req_wdata <= store_data << {off, 3'b000};
              mem_req_wmask <= wmask_next;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (is_load_reg) begin
              state_reg <= RSP;
            end else begin
              state_reg <= IDLE;
              wb_valid  <= 1'b1;
            end
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            state_reg <= IDLE;
            wb_valid  <= 1'b1;
            wb_we     <= 1'b1;
            wb_data   <= load_data;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: stimulus pushes expected requests/writebacks, negedge monitor pops and compares.
module tb_lsu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ls_load, ls_store, ls_unsigned;
  logic [1:0]  ls_size;
  logic [63:0] alu_res, store_data;
  logic [4:0]  rd_idx;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        wb_valid, wb_we, ls_misalign;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  lsu_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ls_load(ls_load), .ls_store(ls_store), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .alu_res(alu_res), .store_data(store_data), .rd_idx(rd_idx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ls_misalign(ls_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        mis;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wb_exp_t  mon_w;
  req_exp_t mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: writebacks are popped on every wb_valid; a pending request is compared
  // every cycle it is presented (stability) and popped on handshake.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 we=%0d rd=%0d data=%h, required no writeback", wb_we, wb_rd, wb_data);
      end else begin
        mon_w = wb_q.pop_front();
        if (wb_we !== mon_w.we || wb_rd !== mon_w.rd || (mon_w.we && wb_data !== mon_w.data) ||
            ls_misalign !== mon_w.mis || cyc != mon_w.cyc) begin
          errors++;
          $display("FAIL wb: got we=%0d rd=%0d data=%h mis=%0d cyc=%0d, required we=%0d rd=%0d data=%h mis=%0d cyc=%0d",
                   wb_we, wb_rd, wb_data, ls_misalign, cyc, mon_w.we, mon_w.rd, mon_w.data, mon_w.mis, mon_w.cyc);
        end else begin
          $display("wb ok: we=%0d rd=%0d data=%h mis=%0d cyc=%0d", wb_we, wb_rd, wb_data, ls_misalign, cyc);
        end
      end
    end
    if (!rst && mem_req_valid) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got mem_req_valid=1 addr=%h, required no request", mem_req_addr);
      end else begin
        mon_r = req_q[0];
        if (mem_req_addr !== mon_r.addr || mem_req_we !== mon_r.we ||
            mem_req_wmask !== mon_r.wmask || mem_req_wdata !== mon_r.wdata) begin
          errors++;
          $display("FAIL req: got addr=%h we=%0d wmask=%h wdata=%h, required addr=%h we=%0d wmask=%h wdata=%h",
                   mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata, mon_r.addr, mon_r.we, mon_r.wmask, mon_r.wdata);
        end
        if (mem_req_ready) begin
          void'(req_q.pop_front());
          $display("req ok: addr=%h we=%0d wmask=%h wdata=%h", mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata);
        end
      end
    end
  end

  task automatic check_busy(input string name);
    checks++;
    if (ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ex_ready=%0d, required 0", name, ex_ready);
    end
  endtask

  // wt = cycles mem_req_ready is held low; stray rsp_valid is driven while waiting.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] rd,
                        input int wt, input logic [63:0] rdata, input logic trap,
                        input logic [63:0] exp_addr, input logic [7:0] exp_wmask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_data);
    int acc;
    wb_exp_t w;
    req_exp_t r;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL ex_ready_idle: got ex_ready=%0d, required 1", ex_ready);
    end
    ex_valid = 1'b1; ls_load = ld; ls_store = st; ls_size = sz; ls_unsigned = uns;
    alu_res = addr; store_data = sd; rd_idx = rd;
    @(posedge clk); #1;
    acc = cyc;
    ex_valid = 1'b0;
    w.rd = rd; w.mis = 1'b0; w.data = 64'd0;
    if (!(ld | st)) begin
      w.we = 1'b1; w.data = addr; w.cyc = acc;
      wb_q.push_back(w);
    end else if (trap) begin
      w.we = 1'b0; w.mis = 1'b1; w.cyc = acc;
      wb_q.push_back(w);
    end else begin
      r.addr = exp_addr; r.we = st & ~ld; r.wmask = exp_wmask; r.wdata = exp_wdata;
      req_q.push_back(r);
      w.we = ld; w.data = exp_data; w.cyc = acc + wt + (ld ? 2 : 1);
      wb_q.push_back(w);
      for (int i = 0; i < wt; i++) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ~rdata;
        @(posedge clk); #1;
        check_busy("ex_ready_req");
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (ld) begin
        check_busy("ex_ready_rsp");
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end
    end
    for (int i = 0; i < 10 && wb_q.size() != 0; i++) @(posedge clk);
    if (wb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL wb_timeout: got no writeback for rd=%0d, required one", rd);
      wb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
    alu_res = 64'd0; store_data = 64'd0; rd_idx = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data, ls_misalign, mem_req_valid, mem_req_we,
         mem_req_addr, mem_req_wdata, mem_req_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wb_valid=%0d wb_we=%0d wb_rd=%0d wb_data=%h mis=%0d req_valid=%0d we=%0d addr=%h wdata=%h wmask=%h, required all 0",
               wb_valid, wb_we, wb_rd, wb_data, ls_misalign, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Response while IDLE must be ignored (monitor flags any writeback)
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;

    //     ld st size  uns addr                    store_data              rd wt rdata                   trap exp_addr        wmask  exp_wdata               exp_data
    run_op(0, 0, 2'b00, 0, 64'h1234,               64'h0,                  5, 0, 64'h0,                  0, 64'h0,          8'h00, 64'h0,                  64'h0);
    run_op(1, 0, 2'b00, 0, 64'h80000003,           64'h0,                  1, 0, 64'h00000000_80000000,  0, 64'h80000000,   8'h08, 64'h0,                  64'hFFFFFFFF_FFFFFF80);
    run_op(0, 1, 2'b01, 0, 64'h80000006,           64'hBEEF,               2, 3, 64'h0,                  0, 64'h80000000,   8'hC0, 64'hBEEF0000_00000000,  64'h0);
    run_op(1, 0, 2'b10, 1, 64'h100,                64'h0,                  3, 2, 64'hDEADBEEF_F0000001,  0, 64'h100,        8'h0F, 64'h0,                  64'h00000000_F0000001);
    run_op(1, 0, 2'b01, 0, 64'h10A,                64'h0,                  7, 0, 64'h11223344_87650000,  0, 64'h108,        8'h0C, 64'h0,                  64'hFFFFFFFF_FFFF8765);
    run_op(1, 0, 2'b11, 0, 64'h208,                64'h0,                  8, 1, 64'h01234567_89ABCDEF,  0, 64'h208,        8'hFF, 64'h0,                  64'h01234567_89ABCDEF);
    run_op(1, 0, 2'b10, 0, 64'h204,                64'h0,                  9, 0, 64'h80000000_00000000,  0, 64'h200,        8'hF0, 64'h0,                  64'hFFFFFFFF_80000000);
    run_op(0, 1, 2'b00, 0, 64'h7,                  64'hA5,                 10, 0, 64'h0,                 0, 64'h0,          8'h80, 64'hA5000000_00000000,  64'h0);
    run_op(0, 1, 2'b11, 0, 64'h40,                 64'hCAFEBABE_12345678,  11, 0, 64'h0,                 0, 64'h40,         8'hFF, 64'hCAFEBABE_12345678,  64'h0);
    run_op(1, 1, 2'b00, 1, 64'h1,                  64'h11,                 12, 0, 64'h00000000_0000FF00, 0, 64'h0,          8'h02, 64'h1100,               64'hFF);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op(1, 0, 2'b10, 0, 64'h102,                64'h0,                  4, 0, 64'h0000AABB_CCDD0000,  1, 64'h0,          8'h00, 64'h0,                  64'h0);
    run_op(0, 1, 2'b01, 0, 64'h7,                  64'h1234,               6, 0, 64'h0,                  1, 64'h0,          8'h00, 64'h0,                  64'h0);
`else
    run_op(1, 0, 2'b10, 0, 64'h102,                64'h0,                  4, 0, 64'h0000AABB_CCDD0000,  0, 64'h100,        8'h3C, 64'h0,                  64'hFFFFFFFF_AABBCCDD);
    run_op(0, 1, 2'b01, 0, 64'h7,                  64'h1234,               6, 1, 64'h0,                  0, 64'h0,          8'h80, 64'h34000000_00000000,  64'h0);
`endif

    // Reset while waiting in RSP: no writeback, stale response ignored
    ex_valid = 1'b1; ls_load = 1'b1; ls_store = 1'b0; ls_size = 2'b11; ls_unsigned = 1'b0;
    alu_res = 64'h300; store_data = 64'h0; rd_idx = 5'd13;
    begin
      req_exp_t r;
      r.addr = 64'h300; r.we = 1'b0; r.wmask = 8'hFF; r.wdata = 64'h0;
      req_q.push_back(r);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_rsp: got ex_ready=%0d wb_valid=%0d req_valid=%0d, required 1 0 0", ex_ready, wb_valid, mem_req_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h5555;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_rsp: got wb_valid=%0d, required 0", wb_valid);
    end
    @(posedge clk); #1;
    run_op(0, 0, 2'b00, 0, 64'h55, 64'h0, 14, 0, 64'h0, 0, 64'h0, 8'h00, 64'h0, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got req_q=%0d wb_q=%0d pending, required 0 0", req_q.size(), wb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port ex_valid  input  1  EX stage presents an operation.
REQ-004 SHALL have port ex_ready  output  1  stage accepts an operation this cycle.
REQ-005 SHALL have ports ls_load / ls_store  input  1 each  operation is load / store; neither set = pass-through.
REQ-006 SHALL have port ls_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-007 SHALL have port ls_unsigned  input  1  zero-extend load data when 1.
REQ-008 SHALL have ports alu_res  input  64 (ALU result / effective address), store_data  input  64, rd_idx  input  5.
REQ-009 SHALL have memory request ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 64, mem_req_we out 1, mem_req_wdata out 64, mem_req_wmask out 8.
REQ-010 SHALL have memory response ports mem_rsp_valid in 1, mem_rsp_rdata in 64.
REQ-011 SHALL have writeback ports wb_valid out 1, wb_we out 1, wb_rd out 5, wb_data out 64, ls_misalign out 1.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, RSP; ex_ready = 1 only in IDLE.
REQ-013 SHALL accept on ex_valid && ex_ready; capture all EX inputs into internal registers.
REQ-014 Pass-through op SHALL give wb_valid=1, wb_we=1, wb_data=alu_res one cycle after accept; FSM stays IDLE.
REQ-015 ls_load && ls_store SHALL be treated as load.
REQ-016 Load/store accept SHALL move IDLE->REQ; in REQ, mem_req_valid=1 with all request fields held stable until mem_req_ready.
REQ-017 mem_req_addr SHALL be {addr[63:3],3'b000}; off = addr[2:0].
REQ-018 mem_req_wmask SHALL be 0x01<<off (B), 0x03<<off (H), 0x0F<<off (W), 0xFF (D), truncated to 8 bits; wdata = store_data << (8*off); mem_req_we = 1 for stores, 0 for loads (wmask still driven).
REQ-019 Store: on accept in REQ, SHALL return to IDLE and pulse wb_valid=1, wb_we=0 next cycle.
REQ-020 Load: on accept in REQ, SHALL move to RSP; mem_rsp_valid in RSP SHALL return to IDLE and pulse wb_valid=1, wb_we=1 next cycle.
REQ-021 Load data SHALL be (mem_rsp_rdata >> 8*off), then sign- or zero-extended from 8/16/32 bits per ls_size/ls_unsigned; D returns the shifted value unchanged.
REQ-022 Minimum latency: load 3 cycles, store 2 cycles accept-to-wb_valid when mem_req_ready=1 and rsp arrives the cycle after request accept.
REQ-023 mem_rsp_valid in IDLE or REQ SHALL be ignored; wb_valid SHALL be a single-cycle pulse; wb_rd = captured rd_idx.
REQ-024 No new operation SHALL be accepted until the current one reaches IDLE (no overlap).

Reset
REQ-025 rst SHALL force state IDLE and clear to 0: wb_valid, wb_we, wb_rd, wb_data, ls_misalign, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask; ex_ready=1 after release.
REQ-026 rst mid-REQ or mid-RSP SHALL abort the operation with no wb_valid pulse; a subsequent stale mem_rsp_valid SHALL be ignored.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: misaligned access (H with off[0]!=0, W with off[1:0]!=0, D with off!=0) SHALL issue no memory request and pulse wb_valid=1, wb_we=0, ls_misalign=1 one cycle after accept.
REQ-028 Macro LSU_MISALIGN_TRAP_EN undefined: ls_misalign SHALL be tied 0; misaligned accesses SHALL proceed per REQ-017/018 with lanes beyond byte 7 dropped.

Verification
REQ-029 Pass-through alu_res=0x1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234.
REQ-030 Load B signed, addr=0x80000003, rdata=0x00000000_80000000 -> wmask=0x08, wb_data=0xFFFF_FFFF_FFFF_FF80.
REQ-031 Store H addr=0x80000006, store_data=0xBEEF, mem_req_ready low 3 cycles -> request stable 4 cycles, addr=0x80000000, wmask=0xC0, wdata=0xBEEF<<48, wb_valid pulse wb_we=0.
REQ-032 Load W unsigned addr=0x100, rdata=0xDEADBEEF_F0000001 -> wb_data=0x00000000_F0000001; ex_ready low throughout.
REQ-033 rst asserted in RSP, then mem_rsp_valid=1 -> no wb_valid; next op accepted normally.
REQ-034 With LSU_MISALIGN_TRAP_EN, load W addr=0x102 -> no mem_req_valid, ls_misalign=1 pulse; without it, wmask=0x3C.
